output_buffer_scan_reader: RTL and testbench

Parametrised read-mode output buffer for the PIM macro's ADC outputs. Snapshots the full PIM output vector, then autonomously scans a programmed run of ADC channels. Each ADC slice is decoded from thermometer code (or passed raw) and pushed into a small FIFO. The CPU-side peripheral drains the FIFO one word per read strobe. It sits between the PIM array output bus and the peripheral register/read-data path.

---
 rtl/output_buffer_scan_reader.sv | 214 +++++++++++++++++++++
 tb/tb_output_buffer_scan_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_buffer_scan_reader.sv
// Read-mode output buffer: snapshots the PIM ADC bus, scans a run of ADC slices,
// thermometer-decodes (or passes raw) each one into a small FIFO drained by CPU reads.
module output_buffer_scan_reader #(
    parameter int NUM_ADC  = 128,
    parameter int ADC_BITS = 8,
    parameter int DEPTH    = 8,
    parameter int IDXW     = $clog2(NUM_ADC)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_ADC*ADC_BITS-1:0]   pim_output_i,
    input  logic                          snap_en_i,
    input  logic                          start_i,
    input  logic [IDXW-1:0]               start_idx_i,
    input  logic [IDXW:0]                 count_i,
    input  logic                          raw_mode_i,
    input  logic                          rd_en_i,
    output logic [31:0]                   rd_data_o,
    output logic                          busy_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [$clog2(DEPTH):0]        level_o,
    output logic                          err_o
);

    localparam int BUSW = NUM_ADC * ADC_BITS;
    localparam int PTRW = $clog2(DEPTH);
    localparam int LVLW = PTRW + 1;
    localparam logic [IDXW:0]   NUM_ADC_W = (IDXW+1)'(NUM_ADC);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NUM_ADC - 1);
    localparam logic [LVLW-1:0] DEPTH_W   = LVLW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [BUSW-1:0]     snapshot_q, snapshot_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [IDXW:0]       remaining_q, remaining_d;
    logic                raw_q, raw_d;
    logic                err_q, err_d;
    logic [PTRW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVLW-1:0]     level_q, level_d;
    logic [31:0]         mem_q [DEPTH];

    logic                fifo_empty;
    logic                fifo_full;
    logic                pop;
    logic                push;
    logic                start_accept;

    logic [ADC_BITS-1:0] slice_arr [NUM_ADC];
    logic [ADC_BITS-1:0] cur_slice;
    logic [ADC_BITS-1:0] inv_slice;
    logic [ADC_BITS-1:0] therm_chk;
    logic                therm_ok;
    logic [4:0]          zero_cnt;
    logic                entry_invalid;
    logic [15:0]         entry_data;
    logic [31:0]         entry_word;

    // ADC 0 sits at the MSB end of the bus.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ADC; gi++) begin : g_slice
            assign slice_arr[gi] = snapshot_q[BUSW-1-ADC_BITS*gi -: ADC_BITS];
        end
    endgenerate

    assign cur_slice = slice_arr[idx_q];

    // A valid code is ones-then-zeros, so its inverse is zeros-then-ones,
    // i.e. inverse+1 is a power of two (or wraps to zero).
    always_comb begin
        inv_slice = ~cur_slice;
        therm_chk = inv_slice & (inv_slice + ADC_BITS'(1));
        therm_ok  = (therm_chk == '0);
        zero_cnt  = '0;
        for (int b = 0; b < ADC_BITS; b++) begin
            zero_cnt = zero_cnt + {4'd0, inv_slice[b]};
        end
    end

    always_comb begin
        entry_invalid = 1'b0;
        entry_data    = '0;
        if (raw_q) begin
            entry_data = 16'(cur_slice);
        end else if (therm_ok) begin
            entry_data = {11'd0, zero_cnt};
        end else begin
            entry_invalid = 1'b1;
        end
        entry_word                = '0;
        entry_word[31]            = entry_invalid;
        entry_word[16 +: IDXW]    = idx_q;
        entry_word[15:0]          = entry_data;
    end

    assign fifo_empty   = (level_q == '0);
    assign fifo_full    = (level_q == DEPTH_W);
    assign pop          = rd_en_i && !fifo_empty;
    assign push         = (state_q == SCAN) && (!fifo_full || pop);
    assign start_accept = (state_q == IDLE) && start_i && (count_i != '0);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_accept) state_d = SCAN;
            SCAN: if (push && remaining_q == (IDXW+1)'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        snapshot_d  = snapshot_q;
        idx_d       = idx_q;
        remaining_d = remaining_q;
        raw_d       = raw_q;
        err_d       = err_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;

        if (state_q == IDLE && snap_en_i) begin
            snapshot_d = pim_output_i;
        end

        if (start_accept) begin
            idx_d       = start_idx_i;
            remaining_d = (count_i > NUM_ADC_W) ? NUM_ADC_W : count_i;
            raw_d       = raw_mode_i;
            err_d       = 1'b0;
        end

        if (push) begin
            idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + IDXW'(1);
            remaining_d = remaining_q - (IDXW+1)'(1);
            wr_ptr_d    = wr_ptr_q + PTRW'(1);
            if (entry_invalid) begin
                err_d = 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVLW'(1);
            2'b01:   level_d = level_q - LVLW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            snapshot_q  <= '0;
            idx_q       <= '0;
            remaining_q <= '0;
            raw_q       <= 1'b0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            snapshot_q  <= snapshot_d;
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
            raw_q       <= raw_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    // Storage needs no reset; occupancy tracking decides what is readable.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_word;
        end
    end

    // Output logic
    always_comb begin
        busy_o    = (state_q == SCAN);
        rd_data_o = '0;
        if (rd_en_i && !fifo_empty) begin
            rd_data_o = mem_q[rd_ptr_q];
        end
    end

    assign empty_o = fifo_empty;
    assign full_o  = fifo_full;
    assign level_o = level_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_output_buffer_scan_reader.sv
// Scoreboard bench: stimulus queues hand-computed FIFO words, a negedge monitor
// checks every read strobe against the queue head.
module tb_output_buffer_scan_reader;

    localparam int NUM_ADC  = 128;
    localparam int ADC_BITS = 8;
    localparam int DEPTH    = 4;
    localparam int IDXW     = 7;

    logic                        clk_i = 1'b0;
    logic                        rst_i;
    logic [NUM_ADC*ADC_BITS-1:0] pim_output_i;
    logic                        snap_en_i;
    logic                        start_i;
    logic [IDXW-1:0]             start_idx_i;
    logic [IDXW:0]               count_i;
    logic                        raw_mode_i;
    logic                        rd_en_i;
    logic [31:0]                 rd_data_o;
    logic                        busy_o;
    logic                        empty_o;
    logic                        full_o;
    logic [2:0]                  level_o;
    logic                        err_o;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q [$];

    output_buffer_scan_reader #(
        .NUM_ADC(NUM_ADC), .ADC_BITS(ADC_BITS), .DEPTH(DEPTH), .IDXW(IDXW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pim_output_i(pim_output_i),
        .snap_en_i(snap_en_i), .start_i(start_i), .start_idx_i(start_idx_i),
        .count_i(count_i), .raw_mode_i(raw_mode_i), .rd_en_i(rd_en_i),
        .rd_data_o(rd_data_o), .busy_o(busy_o), .empty_o(empty_o),
        .full_o(full_o), .level_o(level_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Monitor: every read strobe either pops the next expected word or reads 0 on empty.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (rd_en_i && !empty_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", rd_data_o, 32'hxxxx_xxxx);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    $display("pop: got %h expected %h", rd_data_o, e);
                    check("pop_word", rd_data_o, e);
                end
            end else begin
                check("rd_data_zero", rd_data_o, 32'h0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_adc(input int k, input logic [7:0] v);
        pim_output_i[NUM_ADC*ADC_BITS-1-ADC_BITS*k -: ADC_BITS] = v;
    endtask

    task automatic snap();
        snap_en_i = 1'b1;
        cyc();
        snap_en_i = 1'b0;
    endtask

    task automatic start_scan(input int idx, input int cnt, input bit raw);
        start_i     = 1'b1;
        start_idx_i = idx[IDXW-1:0];
        count_i     = cnt[IDXW:0];
        raw_mode_i  = raw;
        cyc();
        start_i    = 1'b0;
        raw_mode_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy_o; i++) cyc();
        check("idle_timeout", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic drain(input int n);
        rd_en_i = 1'b1;
        repeat (n) cyc();
        rd_en_i = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        rst_i = 1'b1; pim_output_i = '0; snap_en_i = 0; start_i = 0;
        start_idx_i = '0; count_i = '0; raw_mode_i = 0; rd_en_i = 0;
        repeat (2) cyc();
        rst_i = 1'b0;
        check("rst_busy",  {31'd0, busy_o},  32'd0);
        check("rst_empty", {31'd0, empty_o}, 32'd1);
        check("rst_full",  {31'd0, full_o},  32'd0);
        check("rst_level", {29'd0, level_o}, 32'd0);
        check("rst_err",   {31'd0, err_o},   32'd0);

        // Decoded scan of three ADCs
        set_adc(0, 8'hFF); set_adc(1, 8'hF0); set_adc(2, 8'h00);
        snap();
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0001_0004);
        exp_q.push_back(32'h0002_0008);
        start_scan(0, 3, 0);
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy_o) busy_cnt++;
            cyc();
        end
        check("busy_cycles", busy_cnt, 32'd3);
        check("level_3", {29'd0, level_o}, 32'd3);
        drain(3);
        check("empty_after_drain", {31'd0, empty_o}, 32'd1);

        // Invalid thermometer code
        set_adc(5, 8'hA5);
        snap();
        exp_q.push_back(32'h8005_0000);
        start_scan(5, 1, 0);
        wait_idle();
        check("err_set", {31'd0, err_o}, 32'd1);
        drain(1);
        start_scan(0, 0, 0);
        check("cnt0_busy",  {31'd0, busy_o},  32'd0);
        check("cnt0_err",   {31'd0, err_o},   32'd1);
        check("cnt0_level", {29'd0, level_o}, 32'd0);
        exp_q.push_back(32'h0000_0000);
        start_scan(0, 1, 0);
        check("err_cleared", {31'd0, err_o}, 32'd0);
        wait_idle();
        drain(1);

        // Wrap-around from index 126
        set_adc(126, 8'hFE); set_adc(127, 8'hC0);
        snap();
        exp_q.push_back(32'h007E_0001);
        exp_q.push_back(32'h007F_0006);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0001_0004);
        start_scan(126, 4, 0);
        wait_idle();
        check("wrap_level", {29'd0, level_o}, 32'd4);
        drain(4);

        // Backpressure: six entries through a four-deep FIFO
        set_adc(3, 8'h80); set_adc(4, 8'hE0);
        snap();
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0001_0004);
        exp_q.push_back(32'h0002_0008);
        exp_q.push_back(32'h0003_0007);
        exp_q.push_back(32'h0004_0005);
        exp_q.push_back(32'h8005_0000);
        start_scan(0, 6, 0);
        repeat (4) cyc();
        check("bp_full",  {31'd0, full_o},  32'd1);
        check("bp_level", {29'd0, level_o}, 32'd4);
        repeat (3) cyc();
        check("bp_busy_stalled", {31'd0, busy_o}, 32'd1);
        check("bp_still_full",   {31'd0, full_o}, 32'd1);
        drain(8);
        check("bp_empty", {31'd0, empty_o}, 32'd1);
        check("bp_idle",  {31'd0, busy_o},  32'd0);
        check("bp_err",   {31'd0, err_o},   32'd1);

        // Raw mode: stored verbatim, never flagged
        set_adc(7, 8'hF0);
        snap();
        exp_q.push_back(32'h0007_00F0);
        start_scan(7, 1, 1);
        check("raw_err_cleared", {31'd0, err_o}, 32'd0);
        wait_idle();
        exp_q.push_back(32'h0005_00A5);
        start_scan(5, 1, 1);
        wait_idle();
        check("raw_err_stays", {31'd0, err_o}, 32'd0);
        drain(2);

        // start_i and snap_en_i during SCAN are ignored
        set_adc(8, 8'hFF); set_adc(9, 8'hFC); set_adc(10, 8'h00); set_adc(11, 8'hF8);
        snap();
        exp_q.push_back(32'h0008_0000);
        exp_q.push_back(32'h0009_0002);
        exp_q.push_back(32'h000A_0008);
        exp_q.push_back(32'h000B_0003);
        start_scan(8, 4, 0);
        set_adc(8, 8'h00); set_adc(9, 8'h00); set_adc(11, 8'h00);
        snap_en_i = 1'b1; start_i = 1'b1; start_idx_i = '0; count_i = 8'd1;
        cyc();
        snap_en_i = 1'b0; start_i = 1'b0;
        wait_idle();
        check("scan_guard_level", {29'd0, level_o}, 32'd4);
        drain(4);

        // Reset mid-scan
        start_scan(0, 3, 0);
        cyc();
        check("pre_rst_level", {29'd0, level_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("mid_rst_empty", {31'd0, empty_o}, 32'd1);
        check("mid_rst_busy",  {31'd0, busy_o},  32'd0);
        check("mid_rst_level", {29'd0, level_o}, 32'd0);
        cyc();
        rst_i = 1'b0;
        // Snapshot was cleared by reset, so ADC0 reads as 8'h00
        exp_q.push_back(32'h0000_0008);
        start_scan(0, 1, 0);
        wait_idle();
        drain(1);

        check("leftover_expected", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
